// File: rtl/serial_in8_pkg.sv
// Shared constants for the serial_in8 receiver: register map, status bit layout
// and FSM state encodings (PARITY only reachable with SERIAL_IN_PARITY_EN).
package serial_in8_pkg;

  localparam logic [31:0] STAT_ADDR_DEF = 32'h0000_03f0;
  localparam logic [31:0] DATA_ADDR_DEF = 32'h0000_03f4;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVR       = 2;
  localparam int ST_FERR      = 3;
  localparam int ST_PERR      = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_in8_if.sv
// CPU data-memory read port seen by memory-mapped peripherals such as serial_in8.
interface serial_in8_if;
  logic [31:0] rd_addr;
  logic        rd_en;
  logic        hit;
  logic [31:0] r_data;

  modport master (output rd_addr, output rd_en, input hit, input r_data);
  modport slave  (input rd_addr, input rd_en, output hit, output r_data);
endinterface

// File: rtl/serial_in8_fifo.sv
// Small synchronous byte FIFO; a push while full is accepted only when a pop
// happens in the same cycle (the pop frees the slot first).
module serial_in8_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count/pointers define validity, and
  // leaving the array out of the reset lets it map onto plain RAM/flops.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_in8.sv
// Memory-mapped async serial receiver (8N1, or 8E1 when SERIAL_IN_PARITY_EN is
// defined) with a byte FIFO, status/data registers and a not-empty interrupt.
module serial_in8
  import serial_in8_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEF,
  parameter logic [31:0] DATA_ADDR    = DATA_ADDR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_in,
  serial_in8_if.slave bus,
  output logic        rx_irq
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
`ifdef SERIAL_IN_PARITY_EN
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic [2:0]    sync_q;
  logic          rx_s, falling;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          parity_bad;
  logic          tick, stop_sample;
  logic          push_pend;
  logic          ovr_q, ferr_q, perr_q;
  logic          ovr_set, ferr_set, perr_set;
  logic          stat_rd, data_rd;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], rx_in};
  end

  assign rx_s    = sync_q[1];
  assign falling = sync_q[2] & ~sync_q[1];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    tick = 1'b0;
    case (state)
      S_START:                  tick = (timer == HALF_LAST);
      S_DATA, S_PARITY, S_STOP: tick = (timer == BIT_LAST);
      default:                  tick = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (falling) begin
          state   <= S_START;
          timer   <= '0;
          bit_cnt <= '0;
        end
        S_START: begin
          timer <= tick ? '0 : timer + TW'(1);
          if (tick) state <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          timer <= tick ? '0 : timer + TW'(1);
          if (tick) begin
            shift_q <= {rx_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_AFTER_DATA;
          end
        end
        S_PARITY: begin
          timer <= tick ? '0 : timer + TW'(1);
          if (tick) state <= S_STOP;
        end
        S_STOP: begin
          timer <= tick ? '0 : timer + TW'(1);
          if (tick) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SERIAL_IN_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           parity_bad <= 1'b0;
    else if (state == S_PARITY && tick)  parity_bad <= (rx_s != even_parity(shift_q));
  end
`else
  assign parity_bad = 1'b0;
`endif

  assign stop_sample = (state == S_STOP) && tick;
  assign stat_rd     = bus.rd_en && (bus.rd_addr == STAT_ADDR);
  assign data_rd     = bus.rd_en && (bus.rd_addr == DATA_ADDR);
  assign ferr_set    = stop_sample && !rx_s;
  assign perr_set    = stop_sample && rx_s && parity_bad;
  assign ovr_set     = push_pend && fifo_full && !data_rd;

  // shift_q stays stable for the cycle after the stop sample, so it feeds the FIFO directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      push_pend <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      push_pend <= stop_sample && rx_s && !parity_bad;
      ovr_q     <= ovr_set  | (ovr_q  & ~stat_rd);
      ferr_q    <= ferr_set | (ferr_q & ~stat_rd);
      perr_q    <= perr_set | (perr_q & ~stat_rd);
      rx_irq    <= !fifo_empty;
    end
  end

  serial_in8_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_pend),
    .push_data (shift_q),
    .pop       (data_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    bus.hit    = (bus.rd_addr == STAT_ADDR) || (bus.rd_addr == DATA_ADDR);
    bus.r_data = '0;
    if (bus.rd_addr == STAT_ADDR) begin
      bus.r_data[ST_NOT_EMPTY] = !fifo_empty;
      bus.r_data[ST_FULL]      = fifo_full;
      bus.r_data[ST_OVR]       = ovr_q;
      bus.r_data[ST_FERR]      = ferr_q;
      bus.r_data[ST_PERR]      = perr_q;
    end else if (bus.rd_addr == DATA_ADDR) begin
      bus.r_data = {24'b0, fifo_head};
    end
  end

endmodule

// File: tb/tb_serial_in8.sv
// Self-checking bench for serial_in8: directed scenarios plus random frames
// compared against a queue-based model of the receiver's register behaviour.
module tb_serial_in8;

  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam logic [31:0] STAT  = 32'h0000_03f0;
  localparam logic [31:0] DATA  = 32'h0000_03f4;
`ifdef SERIAL_IN_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Stop-bit midpoint, plus two synchroniser flops, plus one cycle to the push.
  localparam int PUSH_CYC = (FRAME_BITS - 1) * CPB + CPB / 2 + 3;

  logic clock, reset, rx_in, rx_irq;
  serial_in8_if bus ();

  serial_in8 #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .rx_in  (rx_in),
    .bus    (bus),
    .rx_irq (rx_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: received bytes in order plus the three sticky flags.
  logic [7:0] ref_q[$];
  bit ref_ovr, ref_ferr, ref_perr;

  function automatic void model_reset();
    ref_q.delete();
    ref_ovr = 0; ref_ferr = 0; ref_perr = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    if (!stop_ok)                 ref_ferr = 1;
    else if (!par_ok)             ref_perr = 1;
    else if (ref_q.size() == DEPTH) ref_ovr = 1;
    else                          ref_q.push_back(b);
  endfunction

  function automatic logic [31:0] model_status_read();
    logic [31:0] s;
    s = '0;
    s[0] = (ref_q.size() != 0);
    s[1] = (ref_q.size() == DEPTH);
    s[2] = ref_ovr;
    s[3] = ref_ferr;
    s[4] = ref_perr;
    ref_ovr = 0; ref_ferr = 0; ref_perr = 0;
    return s;
  endfunction

  function automatic logic [31:0] model_data_read();
    if (ref_q.size() == 0) return 32'h0;
    return {24'h0, ref_q.pop_front()};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef SERIAL_IN_PARITY_EN
    rx_in = (^b) ^ par_flip;
    repeat (CPB) @(negedge clock);
`endif
    rx_in = stop_bit;
    repeat (CPB) @(negedge clock);
    rx_in = 1'b1;
  endtask

  task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data, output logic hit_o);
    bus.rd_addr = addr;
    bus.rd_en   = 1'b1;
    #1;
    data  = bus.r_data;
    hit_o = bus.hit;
    @(negedge clock);
    bus.rd_en   = 1'b0;
    bus.rd_addr = 32'h0;
  endtask

  logic [31:0] got, exp;
  logic        h;

  task automatic test_reset();
    #1;
    n_checks++; if (rx_irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq got=%b exp=0", rx_irq); end
    n_checks++; if (bus.hit !== 1'b0) begin n_errors++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
    n_checks++; if (bus.r_data !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", bus.r_data); end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(4);
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL reset_status got=%h exp=%h", got, exp); end
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        repeat (PUSH_CYC + 1) @(negedge clock);
        n_checks++; if (rx_irq !== 1'b0) begin n_errors++; $display("FAIL irq_early got=%b exp=0", rx_irq); end
        @(negedge clock);
        n_checks++; if (rx_irq !== 1'b1) begin n_errors++; $display("FAIL irq_latency got=%b exp=1", rx_irq); end
      end
    join
    model_frame(8'hA5, 1, 1);
    idle(10);
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL single_status got=%h exp=%h", got, exp); end
    n_checks++; if (h !== 1'b1) begin n_errors++; $display("FAIL status_hit got=%b exp=1", h); end
    cpu_read(DATA, got, h); exp = model_data_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL single_data got=%h exp=%h", got, exp); end
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL single_status2 got=%h exp=%h", got, exp); end
    cpu_read(32'h0000_03f8, got, h);
    n_checks++; if (h !== 1'b0 || got !== 32'h0) begin n_errors++; $display("FAIL miss_addr got=%h/%b exp=0/0", got, h); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_frame(8'(i), 1, 1);
      idle(8);
    end
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL ovr_status got=%h exp=%h", got, exp); end
    for (int i = 0; i < 5; i++) begin
      cpu_read(DATA, got, h); exp = model_data_read();
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL ovr_data%0d got=%h exp=%h", i, got, exp); end
    end
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL ovr_cleared got=%h exp=%h", got, exp); end
  endtask

  task automatic test_glitch();
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(40);
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL glitch_status got=%h exp=%h", got, exp); end
    send_frame(8'h33, 1'b1, 1'b0);
    model_frame(8'h33, 1, 1);
    idle(10);
    cpu_read(DATA, got, h); exp = model_data_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL glitch_next got=%h exp=%h", got, exp); end
  endtask

  task automatic test_ferr();
    send_frame(8'h3C, 1'b0, 1'b0);
    model_frame(8'h3C, 0, 1);
    idle(20);
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL ferr_status got=%h exp=%h", got, exp); end
    cpu_read(DATA, got, h); exp = model_data_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL ferr_data got=%h exp=%h", got, exp); end
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL ferr_cleared got=%h exp=%h", got, exp); end
  endtask

  task automatic test_back_to_back_full_pop();
    logic [31:0] pop_exp, pop_got;
    logic        pop_hit;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i * 16), 1'b1, 1'b0);
      model_frame(8'(i * 16), 1, 1);
      idle(4);
    end
    pop_exp = model_data_read();
    model_frame(8'h50, 1, 1);
    fork
      send_frame(8'h50, 1'b1, 1'b0);
      begin
        repeat (PUSH_CYC) @(negedge clock);
        cpu_read(DATA, pop_got, pop_hit);
      end
    join
    n_checks++; if (pop_got !== pop_exp) begin n_errors++; $display("FAIL pop_push_data got=%h exp=%h", pop_got, pop_exp); end
    idle(10);
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL pop_push_status got=%h exp=%h", got, exp); end
    for (int i = 0; i < 5; i++) begin
      cpu_read(DATA, got, h); exp = model_data_read();
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL pop_push_order%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h77, 1'b1, 1'b0);
    idle(6);
    rx_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_in = i[0];
      idle(CPB);
    end
    reset = 1'b1;
    bus.rd_addr = STAT;
    #1;
    model_reset();
    n_checks++; if (rx_irq !== 1'b0) begin n_errors++; $display("FAIL midreset_irq got=%b exp=0", rx_irq); end
    n_checks++; if (bus.r_data !== 32'h0) begin n_errors++; $display("FAIL midreset_status got=%h exp=0", bus.r_data); end
    bus.rd_addr = 32'h0;
    rx_in = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(10);
    send_frame(8'h5A, 1'b1, 1'b0);
    model_frame(8'h5A, 1, 1);
    idle(10);
    cpu_read(DATA, got, h); exp = model_data_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL midreset_next got=%h exp=%h", got, exp); end
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL midreset_status2 got=%h exp=%h", got, exp); end
  endtask

`ifdef SERIAL_IN_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1, 0);
    idle(10);
    cpu_read(STAT, got, h); exp = model_status_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL perr_status got=%h exp=%h", got, exp); end
    cpu_read(DATA, got, h); exp = model_data_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL perr_data got=%h exp=%h", got, exp); end
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1, 1);
    idle(10);
    cpu_read(DATA, got, h); exp = model_data_read();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL parity_ok_data got=%h exp=%h", got, exp); end
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        logic [7:0] b;
        bit stop_ok, par_ok;
        b       = 8'($urandom);
        stop_ok = ($urandom_range(0, 5) != 0);
        par_ok  = 1;
`ifdef SERIAL_IN_PARITY_EN
        par_ok  = ($urandom_range(0, 5) != 0);
`endif
        send_frame(b, stop_ok, !par_ok);
        model_frame(b, stop_ok, par_ok);
        idle($urandom_range(2, 12));
      end
      cpu_read(STAT, got, h); exp = model_status_read();
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL rand%0d_status got=%h exp=%h", r, got, exp); end
      for (int k = 0; k <= DEPTH; k++) begin
        cpu_read(DATA, got, h); exp = model_data_read();
        n_checks++; if (got !== exp) begin n_errors++; $display("FAIL rand%0d_data%0d got=%h exp=%h", r, k, got, exp); end
      end
      cpu_read(STAT, got, h); exp = model_status_read();
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL rand%0d_status2 got=%h exp=%h", r, got, exp); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    rx_in       = 1'b1;
    bus.rd_en   = 1'b0;
    bus.rd_addr = 32'h0;
    idle(3);
    test_reset();
    test_single();
    test_overrun();
    test_glitch();
    test_ferr();
    test_back_to_back_full_pop();
    test_reset_mid_frame();
`ifdef SERIAL_IN_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
